// File: rtl/uart_transmitter.sv
// uart_transmitter: UART transmit side with a one-entry holding register.
// Sends 1 start bit, DBITS data bits LSB first, an optional parity bit, and
// a stop period of SB_TICK sample_ticks. Each bit lasts 16 sample_ticks.
// A word can be queued while a frame is in flight, so frames go out back-to-back.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// the data and stop periods. ODD_PARITY selects odd (1) or even (0) parity.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   sample_tick  16x oversampling tick, one clk wide
//   tx_valid     upstream has a word on data_in
//   data_in      word to transmit
//   tx_ready     holding register empty; accept on tx_valid && tx_ready
//   tx_busy      frame in progress
//   tx_done      one-clk pulse at the end of each stop period
//   tx           serial line, registered, idles high
module uart_transmitter #(
    parameter int DBITS      = 8,
    parameter int SB_TICK    = 16,
    parameter int ODD_PARITY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             tx_valid,
    input  logic [DBITS-1:0] data_in,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx
);

    localparam int              NBW       = $clog2(DBITS);
    localparam logic [NBW-1:0]  LAST_BIT  = NBW'(DBITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(SB_TICK - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state;
    logic [3:0]       tick;
    logic [NBW-1:0]   nbits;
    logic [DBITS-1:0] shift_reg;
    logic [DBITS-1:0] buffer;
    logic             buf_full;
    logic             stop_end;
    logic             load;

`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`else
    // ODD_PARITY only has meaning when parity is compiled in.
    if (ODD_PARITY != 0) begin : g_parity_ignored
    end
`endif

    assign tx_ready = !buf_full;
    assign tx_busy  = (state != S_IDLE);
    assign stop_end = (state == S_STOP) && sample_tick && (tick == STOP_LAST);
    // A queued word starts from idle immediately, or straight out of the stop
    // period so there is no idle cycle between frames.
    assign load     = buf_full && ((state == S_IDLE) || stop_end);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            tick       <= '0;
            nbits      <= '0;
            shift_reg  <= '0;
            buffer     <= '0;
            buf_full   <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;

            // Accept and drain are exclusive: accept needs buf_full == 0,
            // drain needs buf_full == 1.
            if (tx_valid && !buf_full) begin
                buffer   <= data_in;
                buf_full <= 1'b1;
            end

            case (state)
                S_IDLE: ;
                S_START: if (sample_tick) begin
                    if (tick == 4'd15) begin
                        state <= S_DATA;
                        tick  <= '0;
                        tx    <= shift_reg[0];
                    end else begin
                        tick <= tick + 4'd1;
                    end
                end
                S_DATA: if (sample_tick) begin
                    if (tick == 4'd15) begin
                        tick      <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (nbits == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= parity_bit;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            nbits <= nbits + 1'b1;
                            tx    <= shift_reg[1];
                        end
                    end else begin
                        tick <= tick + 4'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: if (sample_tick) begin
                    if (tick == 4'd15) begin
                        state <= S_STOP;
                        tick  <= '0;
                        tx    <= 1'b1;
                    end else begin
                        tick <= tick + 4'd1;
                    end
                end
`endif
                S_STOP: if (sample_tick) begin
                    if (tick == STOP_LAST) begin
                        tx_done <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tick <= tick + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Load overrides the stop->idle transition above.
            if (load) begin
                state     <= S_START;
                tx        <= 1'b0;
                shift_reg <= buffer;
                buf_full  <= 1'b0;
                tick      <= '0;
                nbits     <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^buffer) ^ (ODD_PARITY != 0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: three instances (default, SB_TICK=8,
// ODD_PARITY=1) share clock, reset and sample_tick. Accepted words are pushed
// to a scoreboard queue and popped when the frame is captured off the line.
module tb_uart_transmitter;
    localparam int ND = 3;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0, reset = 1'b0, sample_tick = 1'b0;
    logic [ND-1:0] tx_valid = '0;
    logic [ND-1:0] tx_ready, tx_busy, tx_done, tx;
    logic [7:0] data_in [ND];
    int tp = 1, tick_cnt = 0;
    int checks = 0, failures = 0;
    int done_cnt [ND];
    logic [7:0] exp_q [$];

    uart_transmitter #(.DBITS(8), .SB_TICK(16), .ODD_PARITY(0)) d0 (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .tx_valid(tx_valid[0]),
        .data_in(data_in[0]), .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]),
        .tx_done(tx_done[0]), .tx(tx[0]));
    uart_transmitter #(.DBITS(8), .SB_TICK(8), .ODD_PARITY(0)) d1 (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .tx_valid(tx_valid[1]),
        .data_in(data_in[1]), .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]),
        .tx_done(tx_done[1]), .tx(tx[1]));
    uart_transmitter #(.DBITS(8), .SB_TICK(16), .ODD_PARITY(1)) d2 (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .tx_valid(tx_valid[2]),
        .data_in(data_in[2]), .tx_ready(tx_ready[2]), .tx_busy(tx_busy[2]),
        .tx_done(tx_done[2]), .tx(tx[2]));

    always #5 clk = ~clk;

    // sample_tick is high one clk out of every tp
    always @(negedge clk) begin
        sample_tick = ((tick_cnt % tp) == 0);
        tick_cnt++;
    end

    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) if (tx_done[i] === 1'b1) done_cnt[i]++;
    end

    // Frame length in sample_ticks for a given stop period
    function automatic int frame_len(input int sb);
        return 16 * (9 + PAR) + sb;
    endfunction

    function automatic logic exp_par(input logic [7:0] w, input int odd);
        return (^w) ^ (odd != 0);
    endfunction

    // Offer a word until accepted; push it to the scoreboard on accept.
    task automatic send(input int d, input logic [7:0] w, input bit hold, output bit to);
        logic rdy;
        to = 1;
        @(negedge clk);
        tx_valid[d] = 1'b1;
        data_in[d]  = w;
        for (int i = 0; i < 2000; i++) begin
            rdy = tx_ready[d];
            @(posedge clk);
            if (rdy === 1'b1) begin
                exp_q.push_back(w);
                to = 0;
                break;
            end
            @(negedge clk);
        end
        #1;
        if (!hold || to) tx_valid[d] = 1'b0;
    endtask

    // Capture one frame, sampling each bit mid-period. Offsets count negedges
    // from the first negedge at which tx is low. cont = frame already started
    // at the current negedge (back-to-back).
    task automatic rx_frame(input int d, input int sb, input bit cont,
                            output logic [7:0] data, output logic par,
                            output logic st, output logic sp, output int len,
                            output logic tx_d, output logic busy_d,
                            output int wait_n, output bit to);
        int bp, nb, lim;
        bp = 16 * tp; nb = 9 + PAR; lim = frame_len(sb) * tp + 40;
        data = 'x; par = 'x; st = 'x; sp = 'x; len = -1;
        tx_d = 'x; busy_d = 'x; wait_n = 0; to = 1;
        if (!cont) begin
            for (int i = 0; i < 400 * tp; i++) begin
                @(negedge clk);
                wait_n++;
                if (tx[d] === 1'b0) begin to = 0; break; end
            end
            if (to) return;
            to = 1;
        end
        for (int off = 0; off < lim; off++) begin
            if (off == bp / 2) st = tx[d];
            for (int k = 0; k < 8; k++) if (off == (k + 1) * bp + bp / 2) data[k] = tx[d];
            if (off == 9 * bp + bp / 2) par = tx[d];
            if (off == nb * bp + (sb * tp) / 2) sp = tx[d];
            if (off > 0 && tx_done[d] === 1'b1) begin
                len = off; tx_d = tx[d]; busy_d = tx_busy[d]; to = 0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            checks++;
            if ({tx[i], tx_ready[i], tx_busy[i], tx_done[i]} !== 4'b1100) begin
                failures++;
                $display("FAIL reset_state dut%0d got tx/rdy/busy/done=%b exp=1100", i,
                         {tx[i], tx_ready[i], tx_busy[i], tx_done[i]});
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] data, e; logic par, st, sp, txd, bsy; int len, wn, dc; bit to;
        dc = done_cnt[0];
        send(0, 8'hA5, 0, to);
        rx_frame(0, 16, 0, data, par, st, sp, len, txd, bsy, wn, to);
        e = exp_q.pop_front();
        checks++; if (to) begin failures++; $display("FAIL single_timeout got=timeout exp=frame"); end
        checks++; if (wn !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", wn); end
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL single_start got=%b exp=0", st); end
        checks++; if (data !== e) begin failures++; $display("FAIL single_data got=%h exp=%h", data, e); end
        checks++; if (sp !== 1'b1) begin failures++; $display("FAIL single_stop got=%b exp=1", sp); end
        checks++; if (len !== frame_len(16)) begin failures++; $display("FAIL single_len got=%0d exp=%0d", len, frame_len(16)); end
        checks++; if ({txd, bsy} !== 2'b10) begin failures++; $display("FAIL single_end_state got=%b exp=10", {txd, bsy}); end
`ifdef UART_TX_PARITY_EN
        checks++; if (par !== exp_par(e, 0)) begin failures++; $display("FAIL single_parity got=%b exp=%b", par, exp_par(e, 0)); end
`endif
        repeat (10) @(negedge clk);
        checks++; if (done_cnt[0] - dc !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt[0] - dc); end
    endtask

    task automatic test_back_to_back();
        int dc;
        dc = done_cnt[0];
        fork
            begin
                bit to;
                send(0, 8'h55, 1, to);
                checks++; if (to) begin failures++; $display("FAIL b2b_accept1 got=timeout exp=accept"); end
                @(negedge clk);
                checks++; if (tx_ready[0] !== 1'b0) begin failures++; $display("FAIL b2b_ready1 got=%b exp=0", tx_ready[0]); end
                send(0, 8'hAA, 0, to);
                checks++; if (to) begin failures++; $display("FAIL b2b_accept2 got=timeout exp=accept"); end
                @(negedge clk);
                checks++; if (tx_ready[0] !== 1'b0) begin failures++; $display("FAIL b2b_ready2 got=%b exp=0", tx_ready[0]); end
            end
            begin
                logic [7:0] data, e; logic par, st, sp, txd, bsy; int len, wn; bit to;
                for (int f = 0; f < 2; f++) begin
                    rx_frame(0, 16, f == 1, data, par, st, sp, len, txd, bsy, wn, to);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    checks++; if (to) begin failures++; $display("FAIL b2b_timeout%0d got=timeout exp=frame", f); end
                    checks++; if (data !== e) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", f, data, e); end
                    checks++; if (len !== frame_len(16)) begin failures++; $display("FAIL b2b_len%0d got=%0d exp=%0d", f, len, frame_len(16)); end
                    // first frame: next start bit already on the line at the done edge
                    checks++; if ({txd, bsy} !== ((f == 0) ? 2'b01 : 2'b10)) begin
                        failures++; $display("FAIL b2b_end_state%0d got=%b exp=%b", f, {txd, bsy}, (f == 0) ? 2'b01 : 2'b10);
                    end
                end
            end
        join
        repeat (10) @(negedge clk);
        checks++; if (done_cnt[0] - dc !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt[0] - dc); end
    endtask

    task automatic test_slow_tick();
        logic [7:0] data, e; logic par, st, sp, txd, bsy; int len, wn, lo, hi; bit to;
        @(negedge clk); tp = 4;
        send(0, 8'h0F, 0, to);
        rx_frame(0, 16, 0, data, par, st, sp, len, txd, bsy, wn, to);
        e = exp_q.pop_front();
        // Start edge is not tick-aligned, so the first bit may be up to 3 clks short.
        hi = frame_len(16) * 4; lo = hi - 3;
        checks++; if (data !== e) begin failures++; $display("FAIL slow_data got=%h exp=%h", data, e); end
        checks++; if (sp !== 1'b1) begin failures++; $display("FAIL slow_stop got=%b exp=1", sp); end
        checks++; if (len < lo || len > hi) begin failures++; $display("FAIL slow_len got=%0d exp=%0d..%0d", len, lo, hi); end
        @(negedge clk); tp = 1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] data, e; logic par, st, sp, txd, bsy; int len, wn; bit to;
        send(0, 8'h3C, 0, to);
        repeat (60) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if ({tx[0], tx_busy[0], tx_ready[0]} !== 3'b101) begin
            failures++; $display("FAIL midreset_state got tx/busy/rdy=%b exp=101", {tx[0], tx_busy[0], tx_ready[0]});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        send(0, 8'h81, 0, to);
        rx_frame(0, 16, 0, data, par, st, sp, len, txd, bsy, wn, to);
        e = exp_q.pop_front();
        checks++; if (data !== e) begin failures++; $display("FAIL midreset_data got=%h exp=%h", data, e); end
        checks++; if (len !== frame_len(16)) begin failures++; $display("FAIL midreset_len got=%0d exp=%0d", len, frame_len(16)); end
    endtask

    task automatic test_short_stop();
        logic [7:0] data, e; logic par, st, sp, txd, bsy; int len, wn; bit to;
        send(1, 8'hFF, 0, to);
        rx_frame(1, 8, 0, data, par, st, sp, len, txd, bsy, wn, to);
        e = exp_q.pop_front();
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL sb8_start got=%b exp=0", st); end
        checks++; if (data !== e) begin failures++; $display("FAIL sb8_data got=%h exp=%h", data, e); end
        checks++; if (len !== frame_len(8)) begin failures++; $display("FAIL sb8_len got=%0d exp=%0d", len, frame_len(8)); end
    endtask

    task automatic test_parity();
        logic [7:0] data, e; logic par, st, sp, txd, bsy; int len, wn, d; bit to;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 0 : 2;
            send(d, 8'h07, 0, to);
            rx_frame(d, 16, 0, data, par, st, sp, len, txd, bsy, wn, to);
            e = exp_q.pop_front();
            checks++; if (data !== e) begin failures++; $display("FAIL par_data%0d got=%h exp=%h", k, data, e); end
            checks++; if (len !== frame_len(16)) begin failures++; $display("FAIL par_len%0d got=%0d exp=%0d", k, len, frame_len(16)); end
            checks++; if (sp !== 1'b1) begin failures++; $display("FAIL par_stop%0d got=%b exp=1", k, sp); end
`ifdef UART_TX_PARITY_EN
            checks++; if (par !== exp_par(e, k)) begin failures++; $display("FAIL par_bit%0d got=%b exp=%b", k, par, exp_par(e, k)); end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < ND; i++) begin data_in[i] = '0; done_cnt[i] = 0; end
        test_reset();
        test_single();
        test_back_to_back();
        test_slow_tick();
        test_reset_mid();
        test_short_stop();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART transmit side paired with uart_receiver. It serialises one DBITS-wide word per frame: 1 start bit, DBITS data bits LSB first, an optional parity bit, and a stop period of SB_TICK ticks. It shares the 16x oversampling sample_tick from the baud rate generator. A one-entry holding register with a valid/ready handshake lets the next word be queued while a frame is in flight, so frames go out back-to-back.

Parameters:
DBITS, 8, data bits per frame (5..8)
SB_TICK, 16, stop-period length in sample_ticks (16 = 1 stop bit; range 1..16)
ODD_PARITY, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
sample_tick  input  1  16x oversampling tick, one clk wide
tx_valid  input  1  upstream has a word on data_in
data_in  input  DBITS  word to transmit
tx_ready  output  1  holding register empty; word accepted when tx_valid && tx_ready at a clk edge
tx_busy  output  1  frame in progress (state != idle)
tx_done  output  1  one-clk pulse at the end of each stop period
tx  output  1  serial line, registered, idles high

Behaviour:
- Reset (reset == 0, asynchronous): state = idle, tx = 1, holding register empty, tx_ready = 1, tx_busy = 0, tx_done = 0, tick/bit counters = 0. Takes effect immediately, including mid-frame.
- Handshake: tx_ready = !buf_full (registered; no combinational path from tx_valid).
  - On accept, data_in is latched and buf_full = 1.
  - A drain and a new accept cannot occur in the same cycle, because tx_ready is 0 while full.
  - tx_valid held high while tx_ready = 0 must not cause a duplicate accept.
- States: idle, start, data, parity (macro only), stop. tx is a register updated on the same edge as state.
  - tx = 0 in start, shift_reg[0] in data, parity bit in parity, 1 in stop and idle.
- idle: if buf_full, go to start on the next edge. On that edge: shift_reg <= buffer, buf_full <= 0, tick <= 0, nbits <= 0.
  - Latency: accept at edge N, tx falls at edge N+1 if the transmitter was idle.
- start: on sample_tick, if tick == 15 go to data with tick <= 0; else tick++.
- data: on sample_tick, if tick == 15:
  - tick <= 0, shift_reg shifts right 1.
  - If nbits == DBITS-1, go to stop (or parity); else nbits++.
  - Otherwise tick++.
  - Each bit lasts exactly 16 sample_ticks.
- parity: one 16-tick bit, then go to stop with tick <= 0.
- stop: on sample_tick, if tick == SB_TICK-1:
  - Pulse tx_done for that single cycle.
  - If buf_full, go directly to start (load as in idle, no idle cycle between frames); else go to idle.
  - Otherwise tick++.
- Clocks without sample_tick hold all counters and tx.
- tx_busy = 1 in start, data, parity and stop.
- Frame length with 8N1: 16 + 16·DBITS + SB_TICK sample_ticks = 160.

Optional Feature:
UART_TX_PARITY_EN
- Defined: parity state is inserted between data and stop.
  - Parity bit = XOR of the DBITS bits of the word, inverted when ODD_PARITY = 1.
  - Computed from the buffer value at load time and held in a register.
  - Frame becomes 176 sample_ticks for 8-bit data with 1 stop bit.
- Undefined: no parity state, parity register or logic; data goes straight to stop; ODD_PARITY has no effect.

Test Plan:
1. sample_tick every clk, send 0xA5 -> tx = 0 for 16 clks, then bits 1,0,1,0,0,1,0,1 at 16 clks each, then 1 for 16 clks. tx_done pulses once at clk 160 after the start edge. tx_busy falls on that edge.
2. Queue 0x55 then 0xAA back-to-back, tx_valid held high -> tx_ready drops after each accept. The second start bit begins on the edge after the first stop ends, with no idle cycle. Exactly two tx_done pulses occur.
3. sample_tick every 4th clk, send 0x0F -> each bit lasts 64 clks. Counters hold between ticks.
4. Assert reset low mid-data of 0x3C -> tx = 1 immediately, tx_busy = 0, tx_ready = 1. After release, a new word 0x81 transmits correctly with no residue.
5. SB_TICK = 8, send 0xFF -> stop period is 8 ticks. Total frame is 152 ticks.
6. UART_TX_PARITY_EN defined, ODD_PARITY = 0, send 0x07 -> parity bit 1. With ODD_PARITY = 1, parity bit 0. Frame is 176 ticks.
